serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned subtractor with borrow-in and borrow-out, computing Diff = x − y − b0 one bit per clock, LSB first. It is the inverse-direction companion to the team's 8-bit conditional sum adder: it recovers an operand from a sum and the other operand, and serves as an independent cross-check of the adder. It accepts one operation per start/done handshake and holds each result stable until the next operation completes.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled at rising clk edge
- x  input  WIDTH  minuend; sampled only on an accepted start
- y  input  WIDTH  subtrahend; sampled only on an accepted start
- b0  input  1  borrow-in; sampled only on an accepted start
- busy  output  1  high while an operation is in progress (state RUN)
- done  output  1  one-cycle pulse: Diff/b8 just updated
- Diff  output  WIDTH  registered difference, held between operations
- b8  output  1  registered borrow-out (1 when x < y + b0)

## Operation
- One clock domain. Reset is asynchronous and active-high.
- States: IDLE, RUN, DONE.
- Internal registers: xs, ys (shift registers, WIDTH bits), br (running borrow), acc (WIDTH-bit result shift register), cnt (counts 0..WIDTH−1).
- IDLE: busy=0, done=0. On start=1: load xs←x, ys←y, br←b0, cnt←0; go to RUN.
- RUN: busy=1. Each edge:
  - d = xs[0] ^ ys[0] ^ br
  - br ← (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & br)
  - acc ← {d, acc[WIDTH−1:1]}; xs, ys shift right by one; cnt ← cnt+1.
  - When the edge processes bit WIDTH−1 (cnt = WIDTH−1): Diff ← final acc value including that bit, b8 ← final borrow, go to DONE.
- DONE: busy=0, done=1 for exactly this cycle.
  - start=1: accept a new operation (load as in IDLE) and go to RUN. Back-to-back operations are allowed.
  - Otherwise go to IDLE.
- start while in RUN is ignored. Inputs x/y/b0 may change freely during RUN.
- Diff and b8 change only on the transition into DONE. They stay stable through IDLE and through the next RUN.
- Arithmetic: modulo 2^WIDTH. {b8, Diff} = {1'b0, x} − y − b0 in (WIDTH+1)-bit two's complement, with b8 being the borrow bit.

## Timing
- Reset values: busy=0, done=0, Diff=0, b8=0, state=IDLE, cnt=0, and all internal registers 0.
- Start accepted at edge E0 → busy=1 after E0. Bits 0..WIDTH−1 are processed at edges E1..E_WIDTH.
- After E_WIDTH: done=1, busy=0, and Diff/b8 are valid. Start-to-result latency is WIDTH edges.
- After E_WIDTH+1: done=0. Next state is RUN if start=1 was sampled, otherwise IDLE.
- Peak throughput is one operation per WIDTH+1 cycles.
- rst asserted at any time, including mid-RUN or during the DONE cycle:
  - All outputs go to their reset values immediately.
  - The operation in flight is discarded; no done pulse is produced for it.
- start held high continuously: a new operation is accepted in every DONE cycle, and busy deasserts only for that single cycle.

## Test plan
- Reset, then start with x=17, y=5, b0=0 → after 8 edges: done=1, Diff=12, b8=0.
- x=12, y=5, b0=1 → Diff=6, b8=0. Then x=0, y=1, b0=0 → Diff=255, b8=1.
- x=195, y=85, b0=0 → Diff=110, b8=0. Then x=0, y=0, b0=0 → Diff=0, b8=0.
- Start x=200, y=100. Pulse start with x=1, y=1 at E3 (during RUN) → second start ignored; result Diff=100, b8=0; exactly one done pulse.
- Hold start high with x=17, y=5 → done pulses every 9 cycles with Diff=12. Diff is stable between pulses, and busy is low for exactly one cycle each time.
- Complete an operation with x=17, y=5 (Diff=12). Start x=50, y=20, then assert rst at E4 → Diff=0, b8=0, busy=0 immediately, and no done pulse follows. After release, x=50, y=20 → Diff=30.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Start/done handshake and operand/result bus for the bit-serial subtractor.
//   start  : request a new operation (master -> slave)
//   x, y   : minuend / subtrahend, WIDTH bits (master -> slave)
//   b0     : borrow-in (master -> slave)
//   busy   : operation in progress (slave -> master)
//   done   : one-cycle pulse, Diff/b8 just updated (slave -> master)
//   Diff   : registered difference, WIDTH bits (slave -> master)
//   b8     : registered borrow-out (slave -> master)
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Diff;
   logic             b8;

   modport master (
      output start, x, y, b0,
      input  busy, done, Diff, b8
   );

   modport slave (
      input  start, x, y, b0,
      output busy, done, Diff, b8
   );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor, LSB first: {b8, Diff} = x - y - b0.
// One operation per start/done handshake; the result is held until the next
// operation completes. Latency from accepted start to done is WIDTH edges.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : serial_subtractor_if.slave (start, x, y, b0 in; busy, done, Diff, b8 out)
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;

   logic [WIDTH-1:0] xs, ys, acc;
   logic             br;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] diff_q;
   logic             b8_q;

   logic             load, step, last;
   logic             busy_c, done_c;
   logic             d, br_nxt;
   logic [WIDTH-1:0] acc_nxt;

   // One full-subtractor cell operating on the current LSBs.
   assign d       = xs[0] ^ ys[0] ^ br;
   assign br_nxt  = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & br);
   assign acc_nxt = {d, acc[WIDTH-1:1]};
   assign last    = (cnt == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and control decode.
   // NOTE: every signal driven here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy_c = 1'b1;
            step   = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done_c = 1'b1;
            // Back-to-back: a start seen in the done cycle is accepted directly.
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath. Start in RUN is ignored because load is only decoded in
   // IDLE/DONE; acc needs no clearing since all WIDTH bits are shifted in.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xs     <= '0;
         ys     <= '0;
         acc    <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         b8_q   <= 1'b0;
      end else if (load) begin
         xs  <= bus.x;
         ys  <= bus.y;
         br  <= bus.b0;
         cnt <= '0;
      end else if (step) begin
         xs  <= xs >> 1;
         ys  <= ys >> 1;
         br  <= br_nxt;
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
         // Publish on the edge that processes the MSB, so the result becomes
         // visible exactly when the state enters DONE.
         if (last) begin
            diff_q <= acc_nxt;
            b8_q   <= br_nxt;
         end
      end
   end

   // busy/done decode directly from the state register, so they follow an
   // asynchronous reset immediately.
   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.Diff = diff_q;
   assign bus.b8   = b8_q;

endmodule
